fb_arbiter: RTL

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_arbiter_pkg.sv | 34 +++
 rtl/fb_arbiter_if.sv | 38 +++
 rtl/fb_wr_fifo.sv | 71 +++++++
 rtl/fb_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/fb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fb_arbiter_pkg
// Shared definitions for the framebuffer arbiter slice: the image geometry,
// bus widths, the grant-state encoding and the write-FIFO entry layout.
// No ports (package).
// ---------------------------------------------------------------------------
package fb_arbiter_pkg;

    localparam int unsigned IMG_W    = 320;
    localparam int unsigned IMG_H    = 240;
    localparam int unsigned FB_WORDS = IMG_W * IMG_H;
    localparam int unsigned ADDR_W   = 17;
    localparam int unsigned DATA_W   = 16;

    // Which client owns the single RAM port in the current cycle
    typedef enum logic [1:0] {
        G_IDLE = 2'd0,
        G_RD   = 2'd1,
        G_WR   = 2'd2
    } grant_t;

    // One queued camera write: target word address plus RGB565 pixel
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    // True when a word address falls inside a framebuffer of 'words' entries
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a,
                                           input int unsigned words);
        return 32'(a) < words;
    endfunction

endpackage

// File: rtl/fb_arbiter_if.sv
// ---------------------------------------------------------------------------
// fb_arbiter_if
// Bundles the three buses that meet at the arbiter:
//   read port   : rd_req, rd_addr -> rd_data          (VGA upscaler)
//   write port  : wr_valid, wr_addr, wr_data -> wr_ready (camera)
//   RAM port    : ram_en, ram_we, ram_addr, ram_wdata -> ram_rdata
// The 'slave' modport is the arbiter's view. The 'master' modport is the
// surrounding system (reader, camera and the RAM itself) seen as one agent.
// ---------------------------------------------------------------------------
interface fb_arbiter_if;
    import fb_arbiter_pkg::*;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_rdata,
        input  rd_data, wr_ready, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_rdata,
        output rd_data, wr_ready, ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/fb_wr_fifo.sv
// ---------------------------------------------------------------------------
// fb_wr_fifo
// Small synchronous FIFO that buffers camera writes while the reader owns
// the RAM. Head entry is visible combinationally on dout.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push, din     : enqueue din (ignored when full)
//   pop, dout     : dequeue head (ignored when empty); dout is the head
//   full, empty   : occupancy flags
//   level         : entries held, 0..DEPTH
// ---------------------------------------------------------------------------
module fb_wr_fifo
    import fb_arbiter_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  wr_entry_t        din,
    output wr_entry_t        dout,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    wr_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two; the level
    // counter is what tells full from empty when the pointers coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
            end
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// ---------------------------------------------------------------------------
// fb_arbiter
// Shares one single-port framebuffer RAM between a VGA reader and a camera
// writer. The reader always wins and sees a fixed 2-cycle read latency;
// camera writes are queued in fb_wr_fifo and retired in idle read slots.
// Ports:
//   vga_clk     : sole clock
//   rst         : synchronous active-high reset
//   bus         : read, write and RAM buses (fb_arbiter_if.slave)
//   status_clr  : clears the sticky error flags
//   fifo_level  : write-FIFO occupancy, 0..FIFO_DEPTH
//   ovf_err     : sticky, camera offered a write while wr_ready was low
//   addr_err    : sticky, camera pushed an address outside the framebuffer
//   grant       : registered owner of the RAM port this cycle
// ---------------------------------------------------------------------------
module fb_arbiter
    import fb_arbiter_pkg::*;
#(
    parameter  int unsigned FB_WORDS   = fb_arbiter_pkg::FB_WORDS,
    parameter  int unsigned FIFO_DEPTH = 8,
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             vga_clk,
    input  logic             rst,
    fb_arbiter_if.slave      bus,
    input  logic             status_clr,
    output logic [LVL_W-1:0] fifo_level,
    output logic             ovf_err,
    output logic             addr_err,
    output grant_t           grant
);

    logic      fifo_full;
    logic      fifo_empty;
    logic      addr_ok;
    logic      offer_ok;
    logic      push;
    logic      pop;
    wr_entry_t wr_in;
    wr_entry_t head;

    // Holding wr_ready low during reset keeps the camera from pushing into
    // a FIFO that is being cleared; it rises as soon as rst drops.
    assign bus.wr_ready = !rst && !fifo_full;
    assign addr_ok      = addr_in_range(bus.wr_addr, FB_WORDS);
    assign offer_ok     = bus.wr_valid && bus.wr_ready;
    assign push         = offer_ok && addr_ok;
    assign pop          = !bus.rd_req && !fifo_empty;
    assign wr_in        = '{addr: bus.wr_addr, data: bus.wr_data};

    // The RAM returns data one cycle after the registered request, so the
    // passthrough gives the reader its fixed 2-cycle latency.
    assign bus.rd_data  = bus.ram_rdata;

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (vga_clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (wr_in),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Grant FSM with registered RAM controls. Reader first, then queued
    // writes, else idle. Address/data are left untouched in idle so the RAM
    // pins do not toggle needlessly.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            grant         <= G_IDLE;
            bus.ram_en    <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
        end else if (bus.rd_req) begin
            grant         <= G_RD;
            bus.ram_en    <= 1'b1;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= bus.rd_addr;
        end else if (!fifo_empty) begin
            grant         <= G_WR;
            bus.ram_en    <= 1'b1;
            bus.ram_we    <= 1'b1;
            bus.ram_addr  <= head.addr;
            bus.ram_wdata <= head.data;
        end else begin
            grant         <= G_IDLE;
            bus.ram_en    <= 1'b0;
            bus.ram_we    <= 1'b0;
        end
    end

    // Sticky error flags; a new error in the same cycle as status_clr wins
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            ovf_err  <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            if (bus.wr_valid && !bus.wr_ready) begin
                ovf_err <= 1'b1;
            end else if (status_clr) begin
                ovf_err <= 1'b0;
            end
            if (offer_ok && !addr_ok) begin
                addr_err <= 1'b1;
            end else if (status_clr) begin
                addr_err <= 1'b0;
            end
        end
    end

endmodule
